// File: rtl/settings_bus_master_if.sv
// Settings bus master port bundle: command/response streams, write strobe bus
// and readback mux select/data. The master modport is the initiator's view.
interface settings_bus_master_if #(
  parameter int AWIDTH = 8
);
  logic [63:0]       cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [63:0]       rsp_tdata;
  logic              rsp_tvalid;
  logic              rsp_tready;
  logic              set_stb;
  logic [AWIDTH-1:0] set_addr;
  logic [31:0]       set_data;
  logic [AWIDTH-1:0] rb_addr;
  logic [31:0]       rb_data;
  logic              busy;

  modport master (
    input  cmd_tdata, cmd_tvalid, rsp_tready, rb_data,
    output cmd_tready, rsp_tdata, rsp_tvalid, set_stb, set_addr, set_data,
           rb_addr, busy
  );

  modport slave (
    output cmd_tdata, cmd_tvalid, rsp_tready, rb_data,
    input  cmd_tready, rsp_tdata, rsp_tvalid, set_stb, set_addr, set_data,
           rb_addr, busy
  );
endinterface

// File: rtl/settings_bus_master.sv
// Settings bus initiator: turns host command words into write strobes or readback
// responses. Define SB_WRITE_ACK_EN to make writes return an ack response too.
module settings_bus_master #(
  parameter int AWIDTH     = 8,
  parameter int STROBE_GAP = 0,
  parameter int RB_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  settings_bus_master_if.master m_bus,
  output logic [2:0]            o_dbg_state
);

  // Handshakes: a beat transfers on the clock edge where valid and ready are both
  // high; valid and data stay stable until then, ready may change freely.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STROBE  = 3'd1,
    S_GAP     = 3'd2,
    S_RB_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

`ifdef SB_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam logic [7:0] GAP_M1 = (STROBE_GAP > 0) ? 8'(STROBE_GAP - 1) : 8'd0;
  localparam logic [7:0] LAT_M1 = 8'(RB_LATENCY - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [7:0]        r_seq;
  logic [AWIDTH-1:0] r_addr;
  logic              r_cmd_tready;
  logic              r_rsp_tvalid;
  logic [63:0]       r_rsp_tdata;
  logic              r_set_stb;
  logic [AWIDTH-1:0] r_set_addr;
  logic [31:0]       r_set_data;
  logic [AWIDTH-1:0] r_rb_addr;

  logic              w_accept;
  logic [AWIDTH-1:0] w_cmd_addr;
  logic [15:0]       w_addr16;
  logic [63:0]       w_wr_ack_word;
  logic              w_unused_bits;

  // r_cmd_tready is only ever set while in IDLE, so it alone qualifies an accept.
  assign w_accept      = m_bus.cmd_tvalid & r_cmd_tready;
  assign w_cmd_addr    = m_bus.cmd_tdata[32 +: AWIDTH];
  assign w_wr_ack_word = {1'b0, 7'b0, r_seq, w_addr16, 32'h0};
  assign w_unused_bits = ^{m_bus.cmd_tdata[62:56], m_bus.cmd_tdata[47:32]};

  always_comb begin
    w_addr16 = '0;
    w_addr16[AWIDTH-1:0] = r_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_seq        <= '0;
      r_addr       <= '0;
      r_cmd_tready <= 1'b0;
      r_rsp_tvalid <= 1'b0;
      r_rsp_tdata  <= '0;
      r_set_stb    <= 1'b0;
      r_set_addr   <= '0;
      r_set_data   <= '0;
      r_rb_addr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd_tready <= 1'b0;
            r_seq        <= m_bus.cmd_tdata[55:48];
            r_addr       <= w_cmd_addr;
            if (m_bus.cmd_tdata[63]) begin
              r_rb_addr <= w_cmd_addr;
              r_cnt     <= LAT_M1;
              r_state   <= S_RB_WAIT;
            end else begin
              r_set_stb  <= 1'b1;
              r_set_addr <= w_cmd_addr;
              r_set_data <= m_bus.cmd_tdata[31:0];
              r_state    <= S_STROBE;
            end
          end else begin
            r_cmd_tready <= 1'b1;
          end
        end
        S_STROBE: begin
          r_set_stb <= 1'b0;
          if (STROBE_GAP > 0) begin
            r_cnt   <= GAP_M1;
            r_state <= S_GAP;
          end else if (WR_ACK) begin
            r_rsp_tvalid <= 1'b1;
            r_rsp_tdata  <= w_wr_ack_word;
            r_state      <= S_RESP;
          end else begin
            r_cmd_tready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else if (WR_ACK) begin
            r_rsp_tvalid <= 1'b1;
            r_rsp_tdata  <= w_wr_ack_word;
            r_state      <= S_RESP;
          end else begin
            r_cmd_tready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        S_RB_WAIT: begin
          // rb_data is sampled in the RB_LATENCY-th cycle after rb_addr changed.
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_rsp_tvalid <= 1'b1;
            r_rsp_tdata  <= {1'b1, 7'b0, r_seq, w_addr16, m_bus.rb_data};
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (m_bus.rsp_tready) begin
            r_rsp_tvalid <= 1'b0;
            r_cmd_tready <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_bus.cmd_tready = r_cmd_tready;
  assign m_bus.rsp_tvalid = r_rsp_tvalid;
  assign m_bus.rsp_tdata  = r_rsp_tdata;
  assign m_bus.set_stb    = r_set_stb;
  assign m_bus.set_addr   = r_set_addr;
  assign m_bus.set_data   = r_set_data;
  assign m_bus.rb_addr    = r_rb_addr;
  assign m_bus.busy       = (r_state != S_IDLE);
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_settings_bus_master.sv
// Directed bench for settings_bus_master: instance a (gap 0, latency 2) and
// instance b (gap 3, latency 1) with hand-computed expected words.
module tb_settings_bus_master;
  localparam int AW = 8;
`ifdef SB_WRITE_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  settings_bus_master_if #(.AWIDTH(AW)) bus_a ();
  settings_bus_master_if #(.AWIDTH(AW)) bus_b ();
  logic [2:0] dbg_a, dbg_b;

  settings_bus_master #(.AWIDTH(AW), .STROBE_GAP(0), .RB_LATENCY(2)) u_dut_a (
    .clk(clk), .rst(rst), .m_bus(bus_a.master), .o_dbg_state(dbg_a));
  settings_bus_master #(.AWIDTH(AW), .STROBE_GAP(3), .RB_LATENCY(1)) u_dut_b (
    .clk(clk), .rst(rst), .m_bus(bus_b.master), .o_dbg_state(dbg_b));

  // readback mux models: a has one register stage (latency 2), b is combinational
  function automatic logic [31:0] rb_fn(input logic [7:0] a);
    return (a == 8'h11) ? 32'h1234_5678 : {24'hA5A5A5, a};
  endfunction
  logic [31:0] r_rb_pipe_a;
  always @(posedge clk) r_rb_pipe_a <= rb_fn(bus_a.rb_addr);
  assign bus_a.rb_data = r_rb_pipe_a;
  assign bus_b.rb_data = rb_fn(bus_b.rb_addr);

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stb_cnt_a = 0, rsp_cnt_a = 0, rsp_cnt_b = 0;
  int exp_stb_a = 0, exp_rsp_a = 0, exp_rsp_b = 0;
  logic [39:0] exp_q[$];
  int stb_cyc_b[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard/monitors
  always @(negedge clk) begin
    if (bus_a.set_stb === 1'b1) stb_cnt_a++;
    if (bus_a.rsp_tvalid === 1'b1 && bus_a.rsp_tready === 1'b1) rsp_cnt_a++;
    if (bus_b.rsp_tvalid === 1'b1 && bus_b.rsp_tready === 1'b1) rsp_cnt_b++;
    if (bus_b.set_stb === 1'b1) begin
      stb_cyc_b.push_back(cyc);
      if (exp_q.size() == 0) check("b_stb_unexpected", 1, 0);
      else check("b_stb_word", {bus_b.set_addr, bus_b.set_data}, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: one write on instance a, checking strobe timing and optional ack
  task automatic wr_a(input string tag, input logic [63:0] cmd, input logic [7:0] ea,
                      input logic [31:0] ed, input logic [63:0] eack);
    check({tag, "_ready_T"}, bus_a.cmd_tready, 1);
    bus_a.cmd_tdata  = cmd;
    bus_a.cmd_tvalid = 1'b1;
    tick;
    bus_a.cmd_tvalid = 1'b0;
    check({tag, "_stb"}, bus_a.set_stb, 1);
    check({tag, "_addr"}, bus_a.set_addr, ea);
    check({tag, "_data"}, bus_a.set_data, ed);
    check({tag, "_ready_T1"}, bus_a.cmd_tready, 0);
    check({tag, "_busy"}, bus_a.busy, 1);
    exp_stb_a++;
    tick;
    check({tag, "_stb_low"}, bus_a.set_stb, 0);
`ifdef SB_WRITE_ACK_EN
    bus_a.rsp_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_ack_valid"}, bus_a.rsp_tvalid, 1);
      check({tag, "_ack_data"}, bus_a.rsp_tdata, eack);
      check({tag, "_ack_noaccept"}, bus_a.cmd_tready, 0);
      if (i == 2) bus_a.rsp_tready = 1'b1;
      tick;
    end
    exp_rsp_a++;
`else
    check({tag, "_noack_data"}, bus_a.rsp_tdata, eack & 64'h0);
`endif
    check({tag, "_ready_back"}, bus_a.cmd_tready, 1);
    check({tag, "_no_rsp"}, bus_a.rsp_tvalid, 0);
  endtask

  initial begin
    int waited;
    int rsp_snap;
    bus_a.cmd_tdata = '0; bus_a.cmd_tvalid = 1'b0; bus_a.rsp_tready = 1'b0;
    bus_b.cmd_tdata = '0; bus_b.cmd_tvalid = 1'b0; bus_b.rsp_tready = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    check("rst_outs_a", {bus_a.cmd_tready, bus_a.busy, bus_a.rsp_tvalid, bus_a.set_stb,
          bus_a.set_addr, bus_a.set_data, bus_a.rb_addr}, 0);
    check("rst_rsp_a", bus_a.rsp_tdata, 0);
    check("rst_outs_b", {bus_b.cmd_tready, bus_b.busy, bus_b.rsp_tvalid, bus_b.set_stb}, 0);
    rst = 1'b0;
    tick;
    check("rel_ready_a", bus_a.cmd_tready, 1);
    check("rel_ready_b", bus_b.cmd_tready, 1);
    bus_a.rsp_tready = 1'b1;
    bus_b.rsp_tready = 1'b1;

    // single writes, second one with ignored bits set
    wr_a("t1", 64'h0000_0000_0005_DEADBEEF, 8'h05, 32'hDEADBEEF, 64'h0000_0005_0000_0000);
    wr_a("tign", 64'h7F00_AB22_CAFE_F00D, 8'h22, 32'hCAFEF00D, 64'h0000_0022_0000_0000);

    // read, latency 2
    check("t3_ready_T", bus_a.cmd_tready, 1);
    bus_a.cmd_tdata = 64'h8042_0011_0000_0000; bus_a.cmd_tvalid = 1'b1;
    tick;
    bus_a.cmd_tvalid = 1'b0;
    check("t3_rb_addr", bus_a.rb_addr, 8'h11);
    check("t3_T1_rsp", bus_a.rsp_tvalid, 0);
    check("t3_T1_ready", bus_a.cmd_tready, 0);
    check("t3_busy", bus_a.busy, 1);
    tick;
    check("t3_T2_rsp", bus_a.rsp_tvalid, 0);
    tick;
    check("t3_T3_rsp", bus_a.rsp_tvalid, 1);
    check("t3_data", bus_a.rsp_tdata, 64'h8042_0011_1234_5678);
    check("t3_no_stb", bus_a.set_stb, 0);
    exp_rsp_a++;
    tick;
    check("t3_rsp_drop", bus_a.rsp_tvalid, 0);
    check("t3_ready_back", bus_a.cmd_tready, 1);
    check("t3_rb_hold", bus_a.rb_addr, 8'h11);
    check("t3_set_hold", {bus_a.set_addr, bus_a.set_data}, {8'h22, 32'hCAFEF00D});

    // read with consumer stalled for 10 cycles, ignored bits set
    bus_a.rsp_tready = 1'b0;
    bus_a.cmd_tdata = 64'hFF99_0033_FFFF_FFFF; bus_a.cmd_tvalid = 1'b1;
    tick;
    bus_a.cmd_tvalid = 1'b0;
    repeat (2) tick;
    rsp_snap = rsp_cnt_a;
    for (int i = 0; i < 10; i++) begin
      check("t4_valid", bus_a.rsp_tvalid, 1);
      check("t4_data", bus_a.rsp_tdata, 64'h8099_0033_A5A5_A533);
      check("t4_ready", bus_a.cmd_tready, 0);
      tick;
    end
    bus_a.rsp_tready = 1'b1;
    tick;
    check("t4_drop", bus_a.rsp_tvalid, 0);
    check("t4_one_hs", rsp_cnt_a - rsp_snap, 1);
    check("t4_idle", bus_a.cmd_tready, 1);
    exp_rsp_a++;

    // back-to-back writes on b, STROBE_GAP=3
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (bus_b.cmd_tready !== 1'b1 && waited < 20) begin
        waited++;
        tick;
      end
      check("b_ready_low", waited, (k == 0) ? 0 : 4 + ACK);
      exp_q.push_back({8'h10 + 8'(k), 32'h1111_0000 + 32'(k)});
      bus_b.cmd_tdata = {16'h0000, 8'(k), 8'h00, 8'h10 + 8'(k), 32'h1111_0000 + 32'(k)};
      bus_b.cmd_tvalid = 1'b1;
      tick;
      bus_b.cmd_tvalid = 1'b0;
    end
    repeat (10) tick;
    check("b_stb_count", stb_cyc_b.size(), 3);
    check("b_space01", stb_cyc_b[1] - stb_cyc_b[0], 5 + ACK);
    check("b_space12", stb_cyc_b[2] - stb_cyc_b[1], 5 + ACK);
    check("b_q_empty", exp_q.size(), 0);
    exp_rsp_b += 3 * ACK;

    // read on b, latency 1
    bus_b.cmd_tdata = 64'h8005_0044_0000_0000; bus_b.cmd_tvalid = 1'b1;
    tick;
    bus_b.cmd_tvalid = 1'b0;
    check("b_rd_rb_addr", bus_b.rb_addr, 8'h44);
    check("b_rd_T1_rsp", bus_b.rsp_tvalid, 0);
    tick;
    check("b_rd_T2_rsp", bus_b.rsp_tvalid, 1);
    check("b_rd_data", bus_b.rsp_tdata, 64'h8005_0044_A5A5_A544);
    exp_rsp_b++;
    tick;
    check("b_rd_drop", bus_b.rsp_tvalid, 0);

    // reset in the accept cycle
    bus_a.cmd_tdata = 64'h0000_0000_0077_0123_4567; bus_a.cmd_tvalid = 1'b1; rst = 1'b1;
    tick;
    bus_a.cmd_tvalid = 1'b0;
    check("r1_outs", {bus_a.cmd_tready, bus_a.busy, bus_a.rsp_tvalid, bus_a.set_stb,
          bus_a.set_addr, bus_a.set_data, bus_a.rb_addr}, 0);
    check("r1_rsp", bus_a.rsp_tdata, 0);
    rst = 1'b0;
    tick;
    check("r1_ready", bus_a.cmd_tready, 1);
    repeat (3) tick;
    check("r1_no_stb", stb_cnt_a, exp_stb_a);

    // reset during RB_WAIT
    bus_a.cmd_tdata = 64'h8001_0055_0000_0000; bus_a.cmd_tvalid = 1'b1;
    tick;
    bus_a.cmd_tvalid = 1'b0;
    rst = 1'b1;
    tick;
    check("r2_outs", {bus_a.cmd_tready, bus_a.busy, bus_a.rsp_tvalid, bus_a.set_stb,
          bus_a.set_addr, bus_a.set_data, bus_a.rb_addr}, 0);
    check("r2_rsp", bus_a.rsp_tdata, 0);
    rst = 1'b0;
    tick;
    check("r2_ready", bus_a.cmd_tready, 1);
    repeat (4) tick;
    check("r2_no_rsp", bus_a.rsp_tvalid, 0);

    // write with seq/addr used for the ack word
    wr_a("t7", 64'h007A_0003_0000_0011, 8'h03, 32'h0000_0011, 64'h007A_0003_0000_0000);

    repeat (3) tick;
    check("a_stb_total", stb_cnt_a, exp_stb_a);
    check("a_rsp_total", rsp_cnt_a, exp_rsp_a);
    check("b_rsp_total", rsp_cnt_b, exp_rsp_b);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
